max_count_n: RTL and testbench



---
 rtl/max_count_n.sv | 94 +++++++++
 tb/tb_max_count_n.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/max_count_n.sv
// N-channel max/min capture over a shared rfd/dav handshake, followed by a
// pulse train on out whose length equals the captured value.
module max_count_n #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic           clock,
  input  logic           reset,
  output logic           rfd,
  input  logic [N-1:0]   dav,
  input  logic [N*W-1:0] x,
  input  logic [N-1:0]   mask,
  input  logic           mode,
  output logic           out,
  output logic [W-1:0]   value,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, WAIT, EMIT} state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state;
  logic [W-1:0] cnt;
  logic [N-1:0] mask_q;
  logic         all_high;
  logic         all_low_q;
  logic [W-1:0] best;
  logic [W-1:0] cand;

  assign all_high  = (&(dav | ~mask)) && (|mask);
  // The return phase is judged against the channel set that took part in the capture.
  assign all_low_q = ~|(dav & mask_q);

  // Chained compare/select; a disabled channel 0 seeds the chain with the
  // neutral value so it can never win against an enabled channel.
  always_comb begin
    best = mask[0] ? x[W-1:0] : (mode ? '1 : '0);
    cand = '0;
    for (int unsigned i = 1; i < N; i++) begin
      cand = x[i*W +: W];
      if (mask[i] && (mode ? (cand < best) : (cand > best)))
        best = cand;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      rfd    <= 1'b1;
      out    <= 1'b0;
      value  <= '0;
      busy   <= 1'b0;
      cnt    <= '0;
      mask_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (all_high) begin
            value  <= best;
            cnt    <= best;
            mask_q <= mask;
            rfd    <= 1'b0;
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (all_low_q) begin
            if (cnt != '0) begin
              out   <= 1'b1;
              state <= EMIT;
            end else begin
              rfd   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        EMIT: begin
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            out   <= 1'b0;
            rfd   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max_count_n.sv
// Randomised self-checking bench for max_count_n against a plain arithmetic
// model of the selected extreme and the expected pulse-train length.
module tb_max_count_n;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock;
  logic           reset;
  logic           rfd;
  logic [N-1:0]   dav;
  logic [N*W-1:0] x;
  logic [N-1:0]   mask;
  logic           mode;
  logic           out;
  logic [W-1:0]   value;
  logic           busy;

  int checks;
  int passed;

  max_count_n #(.N(N), .W(W)) dut (
    .clock(clock),
    .reset(reset),
    .rfd(rfd),
    .dav(dav),
    .x(x),
    .mask(mask),
    .mode(mode),
    .out(out),
    .value(value),
    .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int model_v(logic [N*W-1:0] xv, logic [N-1:0] m, logic md);
    int  r;
    int  s;
    bit  found;
    r = 0;
    found = 0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        s = int'(xv[i*W +: W]);
        if (!found || (md ? (s < r) : (s > r))) r = s;
        found = 1;
      end
    end
    return r;
  endfunction

  // One full handshake: capture, optional dav hold, return, pulse count.
  task automatic run_txn(input logic [N*W-1:0] xv, input logic [N-1:0] m,
                         input logic md, input int hold, input bit noisy);
    int exp_v;
    int cnt;
    exp_v = model_v(xv, m, md);
    @(negedge clock);
    checks++;
    if (rfd !== 1'b1 || busy !== 1'b0)
      $display("FAIL pre_idle: rfd=%b busy=%b required rfd=1 busy=0", rfd, busy);
    else passed++;
    x    = xv;
    mask = m;
    mode = md;
    dav  = m | (N'($urandom) & ~m);
    @(posedge clock);
    @(negedge clock);
    mode = ~md;
    checks++;
    if (rfd !== 1'b0 || busy !== 1'b1 || out !== 1'b0 || int'(value) != exp_v)
      $display("FAIL capture: rfd=%b busy=%b out=%b value=%0d required rfd=0 busy=1 out=0 value=%0d",
               rfd, busy, out, value, exp_v);
    else passed++;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b1 || out !== 1'b0 || rfd !== 1'b0)
        $display("FAIL wait_hold: busy=%b out=%b rfd=%b required busy=1 out=0 rfd=0", busy, out, rfd);
      else passed++;
    end
    dav = N'($urandom) & ~m;
    @(posedge clock);
    @(negedge clock);
    if (exp_v == 0) begin
      checks++;
      if (rfd !== 1'b1 || out !== 1'b0 || busy !== 1'b0)
        $display("FAIL zero_return: rfd=%b out=%b busy=%b required rfd=1 out=0 busy=0", rfd, out, busy);
      else passed++;
      dav = '0;
    end else begin
      cnt = 0;
      while (out === 1'b1 && cnt < 300) begin
        cnt++;
        if (noisy) dav = N'($urandom);
        @(negedge clock);
      end
      dav = '0;
      checks++;
      if (cnt != exp_v)
        $display("FAIL pulse_len: got %0d cycles required %0d", cnt, exp_v);
      else passed++;
      checks++;
      if (rfd !== 1'b1 || busy !== 1'b0 || out !== 1'b0)
        $display("FAIL end_pulse: rfd=%b busy=%b out=%b required rfd=1 busy=0 out=0", rfd, busy, out);
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dav   = '0;
    x     = '0;
    mask  = '1;
    mode  = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (rfd !== 1'b1 || out !== 1'b0 || value !== 8'd0 || busy !== 1'b0)
      $display("FAIL reset: rfd=%b out=%b value=%0d busy=%b required 1 0 0 0", rfd, out, value, busy);
    else passed++;
  endtask

  task automatic test_max();
    run_txn({8'd3, 8'd9, 8'd5, 8'd1}, 4'b1111, 1'b0, 2, 1'b0);
  endtask

  task automatic test_min();
    run_txn({8'd3, 8'd9, 8'd5, 8'd1}, 4'b1111, 1'b1, 0, 1'b0);
  endtask

  task automatic test_mask();
    run_txn({8'd200, 8'd7, 8'd250, 8'd4}, 4'b0101, 1'b0, 1, 1'b0);
  endtask

  task automatic test_zero();
    run_txn('0, 4'b1111, 1'b0, 0, 1'b0);
  endtask

  task automatic test_partial();
    @(negedge clock);
    x    = {8'd4, 8'd6, 8'd2, 8'd8};
    mask = 4'b1111;
    mode = 1'b0;
    dav  = 4'b0111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checks++;
      if (rfd !== 1'b1 || busy !== 1'b0)
        $display("FAIL partial_dav: rfd=%b busy=%b required rfd=1 busy=0", rfd, busy);
      else passed++;
    end
    dav = '0;
    run_txn({8'd4, 8'd6, 8'd2, 8'd8}, 4'b1111, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_emit();
    @(negedge clock);
    x    = {8'd255, 8'd1, 8'd2, 8'd3};
    mask = 4'b1111;
    mode = 1'b0;
    dav  = 4'b1111;
    @(negedge clock);
    dav = '0;
    repeat (20) @(negedge clock);
    checks++;
    if (out !== 1'b1 || value !== 8'd255)
      $display("FAIL emit_long: out=%b value=%0d required out=1 value=255", out, value);
    else passed++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (out !== 1'b0 || rfd !== 1'b1 || busy !== 1'b0 || value !== 8'd0)
      $display("FAIL reset_emit: out=%b rfd=%b busy=%b value=%0d required 0 1 0 0", out, rfd, busy, value);
    else passed++;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (out !== 1'b0)
        $display("FAIL no_resume: out=%b required 0", out);
      else passed++;
    end
    run_txn({8'd0, 8'd2, 8'd1, 8'd0}, 4'b1111, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [N*W-1:0] xv;
    logic [N-1:0]   m;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) xv[i*W +: W] = W'($urandom_range(0, 255));
      m = N'($urandom_range(1, 15));
      run_txn(xv, m, 1'($urandom), $urandom_range(0, 3), 1'b1);
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_max();
    test_min();
    test_mask();
    test_zero();
    test_partial();
    test_reset_emit();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
